// File: rtl/reduce_table_ctrl.sv
// reduce_table_ctrl: reduction table that merges child packets by {AlgType, Index} using a shared pipelined adder.
// Optional REDUCE_LEAF_BYPASS_EN routes unmatched leaf packets straight into the output register.
module reduce_table_ctrl #(
  parameter int ReductionTableSize = 2,
  parameter int AdderLatency = 14,
  parameter int DataWidth = 64,
  parameter int PayloadLen = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth+2:0]  pkt_in,
  input  logic                  pkt_in_valid,
  output logic                  pkt_in_ready,
  output logic                  add_valid,
  output logic [PayloadLen-1:0] add_a,
  output logic [PayloadLen-1:0] add_b,
  input  logic [PayloadLen-1:0] add_result,
  output logic [DataWidth-1:0]  pkt_out,
  output logic                  pkt_out_valid,
  input  logic                  pkt_out_ready
);
  localparam int N = ReductionTableSize;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int V = DataWidth - 1;
  localparam logic [DataWidth-1:0] TOP = {1'b1, {V{1'b0}}};
  logic [DataWidth-1:0] e_pkt [N];
  logic [2:0] e_ch [N];
  logic [3:0] e_wait [N];
  logic [N-1:0] e_cnt, e_leaf, e_out;
  logic [N-1:0] hit, done, cand, free;
  logic [IW-1:0] hit_idx, free_idx, done_idx, out_idx;
  logic [2:0] children;
  logic out_tbl, out_free, hs, any_hit, stall, byp, acc, do_add, do_alloc, ld_tbl;
  always_comb begin
    hit = '0;
    done = '0;
    free = '0;
    hit_idx = '0;
    free_idx = '0;
    done_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      hit[i] = e_pkt[i][V] && e_pkt[i][51:46] == pkt_in[51:46];
      done[i] = e_pkt[i][V] && !e_cnt[i] && (e_ch[i] == 3'd0 || e_leaf[i]);
      free[i] = !e_pkt[i][V];
      if (hit[i]) hit_idx = IW'(i);
      if (free[i]) free_idx = IW'(i);
      if (done[i] && !e_out[i]) done_idx = IW'(i);
    end
  end
  assign cand = done & ~e_out;
  assign children = pkt_in[DataWidth+2:DataWidth];
  assign out_free = !pkt_out_valid || pkt_out_ready;
  assign hs = pkt_out_valid && pkt_out_ready;
  assign any_hit = |hit;
  // a matching entry that is busy or already done must not absorb another child
  assign stall = |(hit & (e_cnt | done));
`ifdef REDUCE_LEAF_BYPASS_EN
  assign byp = !any_hit && children == 3'd0 && out_free;
`else
  assign byp = 1'b0;
`endif
  assign pkt_in_ready = !rst && (any_hit ? !stall : (byp || |free));
  assign acc = pkt_in_valid && pkt_in_ready;
  assign do_add = acc && any_hit;
  assign do_alloc = acc && !any_hit && !byp;
  assign ld_tbl = out_free && |cand && !(acc && byp);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        e_pkt[i] <= '0;
        e_ch[i] <= '0;
        e_wait[i] <= '0;
      end
      e_cnt <= '0;
      e_leaf <= '0;
      e_out <= '0;
    end else
      for (int i = 0; i < N; i++)
        if (hs && out_tbl && out_idx == IW'(i)) begin
          e_pkt[i] <= '0;
          e_ch[i] <= '0;
          e_wait[i] <= '0;
          e_cnt[i] <= 1'b0;
          e_leaf[i] <= 1'b0;
          e_out[i] <= 1'b0;
        end else begin
          if (do_alloc && free_idx == IW'(i)) begin
            e_pkt[i] <= pkt_in[V:0] | TOP;
            e_ch[i] <= children;
            e_leaf[i] <= children == 3'd0;
          end
          if (do_add && hit_idx == IW'(i)) begin
            e_cnt[i] <= 1'b1;
            e_wait[i] <= 4'(AdderLatency);
          end else if (e_cnt[i]) begin
            if (e_wait[i] == 4'd0) begin
              e_pkt[i][PayloadLen-1:0] <= add_result;
              e_ch[i] <= e_ch[i] - 3'd1;
              e_cnt[i] <= 1'b0;
            end else
              e_wait[i] <= e_wait[i] - 4'd1;
          end
          if (ld_tbl && done_idx == IW'(i)) e_out[i] <= 1'b1;
        end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      add_valid <= 1'b0;
      add_a <= '0;
      add_b <= '0;
      pkt_out <= '0;
      pkt_out_valid <= 1'b0;
      out_tbl <= 1'b0;
      out_idx <= '0;
    end else begin
      add_valid <= do_add;
      if (do_add) begin
        add_a <= e_pkt[hit_idx][PayloadLen-1:0];
        add_b <= pkt_in[PayloadLen-1:0];
      end
      if (acc && byp) begin
        pkt_out <= pkt_in[V:0] | TOP;
        pkt_out_valid <= 1'b1;
        out_tbl <= 1'b0;
      end else if (ld_tbl) begin
        pkt_out <= e_pkt[done_idx];
        pkt_out_valid <= 1'b1;
        out_tbl <= 1'b1;
        out_idx <= done_idx;
      end else if (hs)
        pkt_out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_reduce_table_ctrl.sv
// tb_reduce_table_ctrl: scoreboard bench with a pipelined adder model and a per-group sum reference.
module tb_reduce_table_ctrl;
  localparam int AL = 14;
`ifdef REDUCE_LEAF_BYPASS_EN
  localparam int LEAF_LAT = 1;
`else
  localparam int LEAF_LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [66:0] pkt_in = '0;
  logic pkt_in_valid = 1'b0;
  logic pkt_in_ready;
  logic add_valid;
  logic [31:0] add_a, add_b, add_result;
  logic [63:0] pkt_out;
  logic pkt_out_valid;
  logic pkt_out_ready = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int adds = 0;
  logic [63:0] expq[$];
  logic [63:0] seen[$];
  int hsq[$];
  logic [31:0] pipe [AL];
  logic hold_v = 1'b0;
  logic [63:0] hold = '0;
  logic rnd_bp = 1'b0;

  reduce_table_ctrl dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adder model: sum emerges AL cycles after the issue cycle, garbage otherwise
  always @(posedge clk) begin
    pipe[0] <= add_valid ? add_a + add_b : $urandom;
    for (int k = 1; k < AL; k++) pipe[k] <= pipe[k-1];
  end
  assign add_result = pipe[AL-1];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [66:0] mk(input logic [2:0] ch, input logic [5:0] key, input logic [31:0] pl);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {ch, r[63:52], key, r[45:32], pl};
  endfunction

  function automatic logic [63:0] exp_of(input logic [66:0] first, input logic [31:0] sum);
    return {1'b1, first[62:32], sum};
  endfunction

  always @(negedge clk) begin
    int f;
    #3;
    if (add_valid) adds++;
    if (!rst && pkt_out_valid) begin
      if (hold_v) chk("out_stable", pkt_out, hold);
      if (pkt_out_ready) begin
        f = -1;
        for (int i = 0; i < expq.size(); i++)
          if (expq[i][51:46] == pkt_out[51:46]) begin
            f = i;
            break;
          end
        if (f < 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_out: got %h, expected no output", pkt_out);
        end else begin
          chk("pkt_out", pkt_out, expq[f]);
          expq.delete(f);
        end
        seen.push_back(pkt_out);
        hsq.push_back(cyc);
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold = pkt_out;
      end
    end else
      hold_v = 1'b0;
  end

  task automatic send(input logic [66:0] p, output int t);
    int n;
    n = 0;
    if (rnd_bp) pkt_out_ready = $urandom_range(0, 3) != 0;
    pkt_in = p;
    pkt_in_valid = 1'b1;
    #1;
    while (!pkt_in_ready && n < 300) begin
      @(negedge clk);
      if (rnd_bp) pkt_out_ready = $urandom_range(0, 3) != 0;
      #1;
      n++;
    end
    if (!pkt_in_ready) begin
      ncmp++;
      nfail++;
      $display("FAIL send_timeout: ready 0, required 1");
    end
    t = cyc;
    @(negedge clk);
    pkt_in_valid = 1'b0;
  endtask

  task automatic wait_seen(input int total);
    int k;
    k = 0;
    while (seen.size() < total && k < 300) begin
      @(negedge clk);
      #4;
      k++;
    end
    if (seen.size() < total) begin
      ncmp++;
      nfail++;
      $display("FAIL out_timeout: got %0d outputs, required %0d", seen.size(), total);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, n, kk, s, base;
    int rem [2];
    logic [5:0] skey [2];
    logic [66:0] gfirst [2];
    logic [31:0] gsum [2];
    logic [66:0] p, q, r;
    logic [31:0] a, b, c, pl;
    rem[0] = 0;
    rem[1] = 0;
    #3;
    chk("rst_ready", pkt_in_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_pkt_out", pkt_out, 0);
    chk("rst_pkt_out_valid", pkt_out_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", pkt_in_ready, 1);

    send(mk(3'd1, 6'h2a, 32'h5), t);
    send(mk(3'd0, 6'h2a, 32'h7), t);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", pkt_in_ready, 0);
    chk("midrst_add_valid", add_valid, 0);
    chk("midrst_add_a", add_a, 0);
    chk("midrst_add_b", add_b, 0);
    chk("midrst_pkt_out_valid", pkt_out_valid, 0);
    chk("midrst_pkt_out", pkt_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_midrst", pkt_in_ready, 1);
    base = seen.size();
    p = mk(3'd1, 6'h2a, 32'd100);
    expq.push_back(exp_of(p, 32'd300));
    send(p, t);
    repeat (12) @(negedge clk);
    send(mk(3'd0, 6'h2a, 32'd200), t);
    wait_seen(base + 1);
    repeat (10) @(negedge clk);
    chk("midrst_single_out", seen.size() - base, 1);

    base = seen.size();
    p = mk(3'd0, 6'h05, 32'h11);
    expq.push_back(exp_of(p, 32'h11));
    send(p, t);
    #3;
    n = 0;
    while (!pkt_out_valid && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("leaf_latency", cyc - t, LEAF_LAT);
    chk("leaf_payload", pkt_out[31:0], 32'h11);
    chk("leaf_bit63", pkt_out[63], 1);
    wait_seen(base + 1);

    base = seen.size();
    n = adds;
    p = mk(3'd3, 6'h00, 32'd1);
    expq.push_back(exp_of(p, 32'd10));
    send(p, t);
    for (int i = 2; i <= 4; i++) send(mk(3'($urandom), 6'h00, 32'(i)), t);
    wait_seen(base + 1);
    repeat (3) @(negedge clk);
    chk("binom_adds", adds - n, 3);
    chk("binom_outputs", seen.size() - base, 1);
    chk("binom_packet", seen.size() > base ? seen[base] : 64'h0, exp_of(p, 32'd10));

    base = seen.size();
    a = $urandom; b = $urandom; c = $urandom;
    p = mk(3'd1, 6'h11, a);
    q = mk(3'd1, 6'h12, b);
    r = mk(3'd1, 6'h13, c);
    expq.push_back(exp_of(p, a + 32'd1));
    expq.push_back(exp_of(q, b + 32'd2));
    expq.push_back(exp_of(r, c + 32'd3));
    send(p, t);
    send(q, t);
    pkt_in = r;
    pkt_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_stall", pkt_in_ready, 0);
      @(negedge clk);
    end
    pkt_in_valid = 1'b0;
    send(mk(3'd0, 6'h11, 32'd1), t);
    send(r, t);
    chk("full_accept_cycle", t, hsq.size() > 0 ? hsq[hsq.size()-1] + 1 : -1);
    send(mk(3'd0, 6'h12, 32'd2), t);
    send(mk(3'd0, 6'h13, 32'd3), t);
    wait_seen(base + 3);

    a = $urandom; b = $urandom; c = $urandom;
    p = mk(3'd2, 6'h21, a);
    expq.push_back(exp_of(p, a + b + c));
    base = seen.size();
    send(p, t);
    send(mk(3'd0, 6'h21, b), t1);
    send(mk(3'd0, 6'h21, c), t2);
    chk("busy_accept_cycle", t2, t1 + 2 + AL);
    #1;
    chk("busy_add_valid", add_valid, 1);
    chk("busy_add_a", add_a, a + b);
    chk("busy_add_b", add_b, c);
    wait_seen(base + 1);

    @(negedge clk);
    pkt_out_ready = 1'b0;
    base = seen.size();
    p = mk(3'd0, 6'h31, $urandom);
    q = mk(3'd0, 6'h32, $urandom);
    expq.push_back(exp_of(p, p[31:0]));
    expq.push_back(exp_of(q, q[31:0]));
    send(p, t);
    send(q, t);
    repeat (5) @(negedge clk);
    pkt_out_ready = 1'b1;
    wait_seen(base + 2);
    chk("bp_first_key", seen.size() > base ? seen[base][51:46] : 6'h0, 6'h31);
    chk("bp_second_key", seen.size() > base + 1 ? seen[base+1][51:46] : 6'h0, 6'h32);
    chk("bp_back_to_back", hsq.size() > 1 ? hsq[hsq.size()-1] - hsq[hsq.size()-2] : 0, 1);

    rnd_bp = 1'b1;
    for (int it = 0; it < 250; it++) begin
      s = $urandom_range(0, 1);
      if (rem[s] == 0) begin
        kk = $urandom_range(0, 3);
        if (rem[1-s] > 0 && 6'(kk * 13 + 3) == skey[1-s]) kk = (kk + 1) % 4;
        skey[s] = 6'(kk * 13 + 3);
        rem[s] = $urandom_range(0, 3);
        gfirst[s] = mk(3'(rem[s]), skey[s], $urandom);
        gsum[s] = gfirst[s][31:0];
        if (rem[s] == 0) expq.push_back(exp_of(gfirst[s], gsum[s]));
        send(gfirst[s], t);
      end else begin
        pl = $urandom;
        gsum[s] = gsum[s] + pl;
        rem[s]--;
        if (rem[s] == 0) expq.push_back(exp_of(gfirst[s], gsum[s]));
        send(mk(3'($urandom), skey[s], pl), t);
      end
    end
    for (int g = 0; g < 2; g++)
      while (rem[g] > 0) begin
        pl = $urandom;
        gsum[g] = gsum[g] + pl;
        rem[g]--;
        if (rem[g] == 0) expq.push_back(exp_of(gfirst[g], gsum[g]));
        send(mk(3'($urandom), skey[g], pl), t);
      end
    rnd_bp = 1'b0;
    pkt_out_ready = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 1000) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("drain_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
